// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated circular transmit FIFO and baud timing.
// Producers push characters over a valid/ready interface; frames are sent
// LSB first with optional parity and one or two stop bits, back-to-back
// whenever data is queued and transmission is enabled.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_enable,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);
  localparam logic [3:0]      DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic            HAS_PARITY = (PARITY != 0);
  localparam logic            ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNTW-1:0]      count_q;
  logic [DATA_BITS-1:0] head;
  logic                 push;
  logic                 pop;
  logic                 can_pop;

  // Frame datapath
  logic [CW-1:0]        clk_cnt;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 bit_done;

  assign head       = mem[rd_ptr];
  assign tx_ready   = (count_q != FULL_COUNT);
  assign push       = tx_valid && tx_ready;
  assign can_pop    = tx_enable && (count_q != '0);
  assign bit_done   = (clk_cnt == CNT_LAST);
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_empty   = (count_q == '0) && (state_q == S_IDLE);

  // FIFO payload storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and pop decision; the last stop-bit cycle can pop
  // directly into the next start bit so queued frames have no idle gap
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done && (bit_idx == DATA_LAST)) begin
          state_d = HAS_PARITY ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_done && (stop_idx == STOP_LAST)) begin
          if (can_pop) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Serial line decode from registered state; idles high
  always_comb begin
    tx_out = 1'b1;
    case (state_q)
      S_START:  tx_out = 1'b0;
      S_DATA:   tx_out = shift_q[0];
      S_PARITY: tx_out = parity_q;
      default:  tx_out = 1'b1;
    endcase
  end

  // Bit timing, bit/stop indices, shift register and parity capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) || bit_done) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end

      if (state_q != S_DATA) begin
        bit_idx <= '0;
      end else if (bit_done) begin
        bit_idx <= bit_idx + 4'd1;
      end

      if (state_q != S_STOP) begin
        stop_idx <= 1'b0;
      end else if (bit_done) begin
        stop_idx <= ~stop_idx;
      end

      if (pop) begin
        shift_q  <= head;
        parity_q <= (^head) ^ ODD_PARITY;
      end else if ((state_q == S_DATA) && bit_done) begin
        shift_q  <= shift_q >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two instances cover even parity/one stop
// and odd parity/two stops, both with a 4-entry FIFO and 4 clocks per bit.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;

  logic [7:0] data_a;
  logic       valid_a, enable_a, ready_a, out_a, busy_a, empty_a;
  logic [2:0] count_a;

  logic [7:0] data_b;
  logic       valid_b, enable_b, ready_b, out_b, busy_b, empty_b;
  logic [2:0] count_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(4),
    .DATA_BITS(8),
    .PARITY(2),
    .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk),
    .reset(reset),
    .tx_data(data_a),
    .tx_valid(valid_a),
    .tx_ready(ready_a),
    .tx_enable(enable_a),
    .tx_out(out_a),
    .tx_busy(busy_a),
    .tx_empty(empty_a),
    .fifo_count(count_a)
  );

  uart_tx_fifo #(
    .CLKS_PER_BIT(4),
    .DATA_BITS(8),
    .PARITY(1),
    .STOP_BITS(2),
    .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk),
    .reset(reset),
    .tx_data(data_b),
    .tx_valid(valid_b),
    .tx_ready(ready_b),
    .tx_enable(enable_b),
    .tx_out(out_b),
    .tx_busy(busy_b),
    .tx_empty(empty_b),
    .fifo_count(count_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_of(input int sel);
    return (sel == 0) ? out_a : out_b;
  endfunction

  // Samples nbits bit-times of 4 cycles each starting at the current cycle.
  // bits[i] is the first sample of bit i; stable[i] is set if all four agree.
  task automatic capture_frame(input int sel, input int nbits,
                               output logic [11:0] bits,
                               output logic [11:0] stable,
                               output logic last_busy);
    bits = '0;
    stable = '0;
    last_busy = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      logic first;
      logic same;
      first = line_of(sel);
      same = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (line_of(sel) != first) same = 1'b0;
        last_busy = (sel == 0) ? busy_a : busy_b;
        step();
      end
      bits[b] = first;
      stable[b] = same;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    data_a = '0; valid_a = 1'b0; enable_a = 1'b0;
    data_b = '0; valid_b = 1'b0; enable_b = 1'b0;
    #2;
    checks++; if (out_a !== 1'b1) begin errors++; $display("FAIL reset_tx_out: got %b expected 1", out_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (empty_a !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_a); end
    checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_a); end
    checks++; if (out_b !== 1'b1) begin errors++; $display("FAIL reset_tx_out_b: got %b expected 1", out_b); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    checks++; if ({out_a, busy_a, count_a} !== {1'b1, 1'b0, 3'd0}) begin
      errors++; $display("FAIL reset_release_idle: got out=%b busy=%b count=%0d expected 1 0 0", out_a, busy_a, count_a);
    end
  endtask

  task automatic test_single_even();
    logic [11:0] bits, stab;
    logic lb;
    enable_a = 1'b1;
    data_a = 8'h6C; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    checks++; if (count_a !== 3'd1) begin errors++; $display("FAIL single_count_push: got %0d expected 1", count_a); end
    checks++; if (out_a !== 1'b1) begin errors++; $display("FAIL single_line_before_pop: got %b expected 1", out_a); end
    step();
    checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL single_start_latency: got %b expected 0", out_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL single_busy_at_pop: got %b expected 1", busy_a); end
    checks++; if (count_a !== 3'd0) begin errors++; $display("FAIL single_count_pop: got %0d expected 0", count_a); end
    capture_frame(0, 11, bits, stab, lb);
    // 0x6C even: start 0, data 0,0,1,1,0,1,1,0, parity 0, stop 1
    checks++; if (bits !== 12'h4D8) begin errors++; $display("FAIL single_frame_bits: got %h expected 4d8", bits); end
    checks++; if (stab !== 12'h7FF) begin errors++; $display("FAIL single_bit_width: got %h expected 7ff", stab); end
    checks++; if (lb !== 1'b1) begin errors++; $display("FAIL single_busy_last_stop: got %b expected 1", lb); end
    checks++; if ({empty_a, busy_a, out_a} !== 3'b101) begin
      errors++; $display("FAIL single_end_44: got empty=%b busy=%b out=%b expected 1 0 1", empty_a, busy_a, out_a);
    end
  endtask

  task automatic test_odd_two_stop();
    logic [11:0] bits, stab;
    logic lb;
    enable_b = 1'b1;
    data_b = 8'h6C; valid_b = 1'b1;
    step();
    valid_b = 1'b0;
    step();
    checks++; if (out_b !== 1'b0) begin errors++; $display("FAIL odd_start_latency: got %b expected 0", out_b); end
    capture_frame(1, 12, bits, stab, lb);
    // 0x6C odd: parity 1, then two stop bits
    checks++; if (bits !== 12'hED8) begin errors++; $display("FAIL odd_frame_bits: got %h expected ed8", bits); end
    checks++; if (stab !== 12'hFFF) begin errors++; $display("FAIL odd_bit_width: got %h expected fff", stab); end
    checks++; if (lb !== 1'b1) begin errors++; $display("FAIL odd_busy_last_stop: got %b expected 1", lb); end
    checks++; if ({empty_b, busy_b} !== 2'b10) begin
      errors++; $display("FAIL odd_end_48: got empty=%b busy=%b expected 1 0", empty_b, busy_b);
    end
  endtask

  task automatic test_fill_overflow();
    logic [11:0] bits, stab;
    logic lb;
    logic [11:0] exp_frames [4];
    logic [2:0]  exp_count  [5];
    exp_frames[0] = 12'h602;  // 0x01, parity 1
    exp_frames[1] = 12'h604;  // 0x02, parity 1
    exp_frames[2] = 12'h406;  // 0x03, parity 0
    exp_frames[3] = 12'h608;  // 0x04, parity 1
    exp_count[0] = 3'd1; exp_count[1] = 3'd2; exp_count[2] = 3'd3;
    exp_count[3] = 3'd4; exp_count[4] = 3'd4;
    enable_a = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      data_a = 8'(v); valid_a = 1'b1;
      step();
      checks++; if (count_a !== exp_count[v-1]) begin
        errors++; $display("FAIL fill_count_%0d: got %0d expected %0d", v, count_a, exp_count[v-1]);
      end
    end
    valid_a = 1'b0;
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL fill_ready_full: got %b expected 0", ready_a); end
    checks++; if (out_a !== 1'b1) begin errors++; $display("FAIL fill_line_disabled: got %b expected 1", out_a); end
    enable_a = 1'b1;
    step();
    checks++; if ({out_a, ready_a, count_a} !== {1'b0, 1'b1, 3'd3}) begin
      errors++; $display("FAIL fill_first_pop: got out=%b ready=%b count=%0d expected 0 1 3", out_a, ready_a, count_a);
    end
    for (int f = 0; f < 4; f++) begin
      capture_frame(0, 11, bits, stab, lb);
      checks++; if (bits !== exp_frames[f]) begin
        errors++; $display("FAIL fill_frame_%0d: got %h expected %h", f, bits, exp_frames[f]);
      end
      checks++; if (stab !== 12'h7FF) begin
        errors++; $display("FAIL fill_frame_width_%0d: got %h expected 7ff", f, stab);
      end
    end
    checks++; if ({empty_a, out_a} !== 2'b11) begin
      errors++; $display("FAIL fill_drained: got empty=%b out=%b expected 1 1", empty_a, out_a);
    end
  endtask

  task automatic test_enable_drop();
    logic [11:0] bits, stab;
    logic lb;
    logic quiet;
    enable_a = 1'b0;
    data_a = 8'hA5; valid_a = 1'b1;
    step();
    data_a = 8'h3C;
    step();
    valid_a = 1'b0;
    enable_a = 1'b1;
    step();
    checks++; if ({out_a, count_a} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL drop_first_pop: got out=%b count=%0d expected 0 1", out_a, count_a);
    end
    fork
      capture_frame(0, 11, bits, stab, lb);
      begin
        repeat (14) step();
        enable_a = 1'b0;
      end
    join
    checks++; if (bits !== 12'h54A) begin errors++; $display("FAIL drop_frame_a5: got %h expected 54a", bits); end
    checks++; if ({out_a, busy_a, count_a, empty_a} !== {1'b1, 1'b0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL drop_held: got out=%b busy=%b count=%0d empty=%b expected 1 0 1 0", out_a, busy_a, count_a, empty_a);
    end
    quiet = 1'b1;
    repeat (20) begin
      step();
      if (!(out_a === 1'b1 && busy_a === 1'b0 && count_a === 3'd1)) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL drop_stays_idle: got %b expected 1", quiet); end
    enable_a = 1'b1;
    step();
    checks++; if (out_a !== 1'b0) begin errors++; $display("FAIL drop_reenable_start: got %b expected 0", out_a); end
    capture_frame(0, 11, bits, stab, lb);
    checks++; if (bits !== 12'h478) begin errors++; $display("FAIL drop_frame_3c: got %h expected 478", bits); end
  endtask

  // Earlier scenarios leave both pointers at 3 (1 + 4 + 2 transfers, mod 4)
  task automatic test_wrap_simultaneous();
    logic [11:0] bits, stab;
    logic lb;
    enable_a = 1'b1;
    data_a = 8'h11; valid_a = 1'b1;
    step();
    data_a = 8'h22;
    step();
    valid_a = 1'b0;
    checks++; if ({count_a, out_a} !== {3'd1, 1'b0}) begin
      errors++; $display("FAIL wrap_count_simul: got count=%0d out=%b expected 1 0", count_a, out_a);
    end
    capture_frame(0, 11, bits, stab, lb);
    checks++; if (bits !== 12'h422) begin errors++; $display("FAIL wrap_frame_11: got %h expected 422", bits); end
    checks++; if ({count_a, out_a} !== {3'd0, 1'b0}) begin
      errors++; $display("FAIL wrap_back_to_back: got count=%0d out=%b expected 0 0", count_a, out_a);
    end
    capture_frame(0, 11, bits, stab, lb);
    checks++; if (bits !== 12'h444) begin errors++; $display("FAIL wrap_frame_22: got %h expected 444", bits); end
  endtask

  task automatic test_async_reset();
    logic quiet;
    enable_a = 1'b1;
    data_a = 8'h55; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    step();
    data_a = 8'h0F; valid_a = 1'b1;
    step();
    valid_a = 1'b0;
    repeat (7) step();
    // cycle 8 after pop: data bit 1 of 0x55 is 0
    checks++; if ({out_a, busy_a, count_a} !== {1'b0, 1'b1, 3'd1}) begin
      errors++; $display("FAIL areset_pre: got out=%b busy=%b count=%0d expected 0 1 1", out_a, busy_a, count_a);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if ({out_a, busy_a, count_a, ready_a, empty_a} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL areset_immediate: got out=%b busy=%b count=%0d ready=%b empty=%b expected 1 0 0 1 1",
                         out_a, busy_a, count_a, ready_a, empty_a);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    quiet = 1'b1;
    repeat (60) begin
      step();
      if (!(out_a === 1'b1 && busy_a === 1'b0 && count_a === 3'd0)) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL areset_no_activity: got %b expected 1", quiet); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_even();
    test_odd_two_stop();
    test_fill_overflow();
    test_enable_drop();
    test_wrap_simultaneous();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
